axi_req_master: RTL and testbench

- Upstream bus master for the memory/FIFO slave on the simple valid/ready bus (write_* and read_* channels).
- Accepts read/write commands from a producer (testbench sequencer or CPU-side logic) and buffers them in a small command FIFO.
- Issues one transaction at a time on the bus, honouring the slave's registered-ready handshake.
- Returns one response per command: write ack, or read data.

---
 rtl/axi_req_master_pkg.sv | 26 ++
 rtl/axi_req_master_if.sv | 26 ++
 rtl/axi_req_master_req_cmd_fifo.sv | 52 +++++
 rtl/axi_req_master.sv | 213 +++++++++++++++++++++
 tb/tb_axi_req_master.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_req_master_pkg.sv
// Shared types and defaults for the request master.
//   req_cmd_t   : one queued command {write, addr, data}
//   req_state_e : master FSM states
//   REQ_*       : default depth / timeout / bus widths
package axi_req_master_pkg;

    localparam int REQ_CMD_DEPTH      = 4;
    localparam int REQ_TIMEOUT_CYCLES = 256;
    localparam int REQ_ADDR_W         = 32;
    localparam int REQ_DATA_W         = 32;

    typedef struct packed {
        logic                  write;
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_DATA_W-1:0] data;
    } req_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_RD_REQ,
        ST_RD_DATA,
        ST_RSP
    } req_state_e;

endpackage

// File: rtl/axi_req_master_if.sv
// Simple valid/ready memory bus with separate write and read channels.
//   master modport: drives *_valid, addresses, write data; takes readies, read data
//   slave modport : the mirror image
interface axi_req_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              m_write_valid;
    logic              m_write_ready;
    logic [ADDR_W-1:0] m_write_addr;
    logic [DATA_W-1:0] m_write_data;
    logic              m_read_valid;
    logic              m_read_ready;
    logic [ADDR_W-1:0] m_read_addr;
    logic [DATA_W-1:0] m_read_data;

    modport master (
        output m_write_valid, m_write_addr, m_write_data, m_read_valid, m_read_addr,
        input  m_write_ready, m_read_ready, m_read_data
    );

    modport slave (
        input  m_write_valid, m_write_addr, m_write_data, m_read_valid, m_read_addr,
        output m_write_ready, m_read_ready, m_read_data
    );
endinterface

// File: rtl/axi_req_master_req_cmd_fifo.sv
// Synchronous command FIFO (power-of-two depth, pointers wrap naturally).
//   push/push_data : write when not full (a same-cycle pop does not make room)
//   pop/head       : head is the oldest entry; pop ignored when empty
//   full/empty/count
module req_cmd_fifo
    import axi_req_master_pkg::*;
#(
    parameter int  DEPTH = REQ_CMD_DEPTH,
    parameter type T     = req_cmd_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  T                       push_data,
    input  logic                   pop,
    output T                       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/axi_req_master.sv
// Bus master: queues read/write commands, runs one bus transaction at a
// time, returns one response per command in order.
//   cmd_*  : command input (valid/ready), cmd_ready = FIFO not full
//   rsp_*  : response output (valid/ready); rdata is 0 for writes
//   busy   : FSM active or commands queued
//   bus    : master side of the valid/ready memory bus
// Optional: define AXI_REQ_TIMEOUT_EN to abandon a request after
// TIMEOUT_CYCLES valid cycles without a handshake (rsp_err=1).
module axi_req_master
    import axi_req_master_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int CMD_DEPTH      = REQ_CMD_DEPTH,
    parameter int TIMEOUT_CYCLES = REQ_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    axi_req_master_if.master  bus
);
    if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("CMD_DEPTH must be a power of two >= 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 1");
    end

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

    cmd_t                       head;
    logic                       fifo_full, fifo_empty, pop;
    logic [$clog2(CMD_DEPTH):0] fifo_count;

    req_cmd_fifo #(.DEPTH(CMD_DEPTH), .T(cmd_t)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cmd_valid),
        .push_data ({cmd_write, cmd_addr, cmd_wdata}),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    req_state_e        st_q, st_d;
    logic              wv_q, wv_d, rv_q, rv_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rv_rsp_q, rv_rsp_d;
    logic              rw_q, rw_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
`ifdef AXI_REQ_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q, err_d;
    logic              timed_out;
    // Counts cycles the request valid is actually on the bus.
    assign timed_out = (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        st_d     = st_q;
        wv_d     = wv_q;
        rv_d     = rv_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rv_rsp_d = rv_rsp_q;
        rw_d     = rw_q;
        rdata_d  = rdata_q;
        pop      = 1'b0;
`ifdef AXI_REQ_TIMEOUT_EN
        wait_d   = wait_q;
        err_d    = err_q;
`endif
        case (st_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    addr_d  = head.addr;
                    wdata_d = head.data;
                    st_d    = head.write ? ST_WR_REQ : ST_RD_REQ;
`ifdef AXI_REQ_TIMEOUT_EN
                    wait_d  = '0;
`endif
                end
            end
            ST_WR_REQ: begin
                // Valid rises one edge after entry; ready before that is ignored.
                wv_d = 1'b1;
                if (wv_q && bus.m_write_ready) begin
                    wv_d     = 1'b0;
                    rv_rsp_d = 1'b1;
                    rw_d     = 1'b1;
                    rdata_d  = '0;
`ifdef AXI_REQ_TIMEOUT_EN
                    err_d    = 1'b0;
`endif
                    st_d     = ST_RSP;
                end
`ifdef AXI_REQ_TIMEOUT_EN
                else if (wv_q && timed_out) begin
                    wv_d     = 1'b0;
                    rv_rsp_d = 1'b1;
                    rw_d     = 1'b1;
                    rdata_d  = '0;
                    err_d    = 1'b1;
                    st_d     = ST_RSP;
                end else if (wv_q) begin
                    wait_d = wait_q + 1'b1;
                end
`endif
            end
            ST_RD_REQ: begin
                rv_d = 1'b1;
                if (rv_q && bus.m_read_ready) begin
                    rv_d = 1'b0;
                    st_d = ST_RD_DATA;
                end
`ifdef AXI_REQ_TIMEOUT_EN
                else if (rv_q && timed_out) begin
                    rv_d     = 1'b0;
                    rv_rsp_d = 1'b1;
                    rw_d     = 1'b0;
                    rdata_d  = '0;
                    err_d    = 1'b1;
                    st_d     = ST_RSP;
                end else if (rv_q) begin
                    wait_d = wait_q + 1'b1;
                end
`endif
            end
            ST_RD_DATA: begin
                // Slave presents read data exactly one cycle after the handshake.
                rdata_d  = bus.m_read_data;
                rw_d     = 1'b0;
                rv_rsp_d = 1'b1;
`ifdef AXI_REQ_TIMEOUT_EN
                err_d    = 1'b0;
`endif
                st_d     = ST_RSP;
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    rv_rsp_d = 1'b0;
                    st_d     = ST_IDLE;
                end
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q     <= ST_IDLE;
            wv_q     <= 1'b0;
            rv_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rv_rsp_q <= 1'b0;
            rw_q     <= 1'b0;
            rdata_q  <= '0;
`ifdef AXI_REQ_TIMEOUT_EN
            wait_q   <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            st_q     <= st_d;
            wv_q     <= wv_d;
            rv_q     <= rv_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rv_rsp_q <= rv_rsp_d;
            rw_q     <= rw_d;
            rdata_q  <= rdata_d;
`ifdef AXI_REQ_TIMEOUT_EN
            wait_q   <= wait_d;
            err_q    <= err_d;
`endif
        end
    end

    assign cmd_ready         = !fifo_full;
    assign busy              = (st_q != ST_IDLE) || (fifo_count != '0);
    assign bus.m_write_valid = wv_q;
    assign bus.m_write_addr  = addr_q;
    assign bus.m_write_data  = wdata_q;
    assign bus.m_read_valid  = rv_q;
    assign bus.m_read_addr   = addr_q;
    assign rsp_valid         = rv_rsp_q;
    assign rsp_write         = rw_q;
    assign rsp_rdata         = rdata_q;
`ifdef AXI_REQ_TIMEOUT_EN
    assign rsp_err           = err_q;
`else
    assign rsp_err           = 1'b0;
`endif
endmodule

// File: tb/tb_axi_req_master.sv
module tb_axi_req_master;
    localparam int AW = 32, DW = 32, DEPTH = 4, TMO = 256;

    typedef struct packed {
        logic          write;
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    typedef struct {
        bit            write;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        exp_t          exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_write, rsp_err, busy;
    logic [DW-1:0] rsp_rdata;

    axi_req_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    axi_req_master #(.ADDR_W(AW), .DATA_W(DW), .CMD_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .bus(bus.master)
    );

    int   checks = 0, failures = 0;
    exp_t exp_q[$];
    int   viol_both = 0, stab_viol = 0, wr_xfers = 0, rd_xfers = 0, wr_cmds = 0;
    int   rsp_hi = 0;
    int   wr_delay = 0, rd_delay = 0;
    bit   rd_block = 0, keep_ready = 0;
    bit   wr_hs = 0, rd_hs = 0;
    logic [AW-1:0] rd_hs_addr;
    logic [DW-1:0] mem [logic [AW-1:0]];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Response scoreboard plus bus/response protocol watch, sampled mid-cycle.
    initial begin : mon
        exp_t          e;
        logic          pw_v, pw_hs, pr_v, pr_hs, prs_v, prs_acc, prs_w, prs_e;
        logic [AW-1:0] pw_a, pr_a;
        logic [DW-1:0] pw_d, prs_d;
        pw_v = 0; pw_hs = 0; pr_v = 0; pr_hs = 0; prs_v = 0; prs_acc = 0;
        pw_a = '0; pr_a = '0; pw_d = '0; prs_d = '0; prs_w = 0; prs_e = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pw_v = 0; pr_v = 0; prs_v = 0;
            end else begin
                if (bus.m_write_valid && bus.m_read_valid) viol_both++;
                if (pw_v && !pw_hs && bus.m_write_valid &&
                    {bus.m_write_addr, bus.m_write_data} !== {pw_a, pw_d}) stab_viol++;
                if (pr_v && !pr_hs && bus.m_read_valid && bus.m_read_addr !== pr_a) stab_viol++;
`ifndef AXI_REQ_TIMEOUT_EN
                if (pw_v && !pw_hs && !bus.m_write_valid) stab_viol++;
                if (pr_v && !pr_hs && !bus.m_read_valid) stab_viol++;
`endif
                if (prs_v && !prs_acc &&
                    (!rsp_valid || {rsp_write, rsp_rdata, rsp_err} !== {prs_w, prs_d, prs_e})) stab_viol++;
                pw_hs = bus.m_write_valid && bus.m_write_ready;
                if (pw_hs) begin
                    mem[bus.m_write_addr] = bus.m_write_data;
                    wr_xfers++;
                    wr_hs = 1;
                end
                pr_hs = bus.m_read_valid && bus.m_read_ready;
                if (pr_hs) begin
                    rd_xfers++;
                    rd_hs = 1;
                    rd_hs_addr = bus.m_read_addr;
                end
                if (rsp_valid) rsp_hi++;
                prs_acc = rsp_valid && rsp_ready;
                if (prs_acc) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL rsp_unexpected got write=%0b rdata=%0h err=%0b", rsp_write, rsp_rdata, rsp_err);
                    end else begin
                        e = exp_q.pop_front();
                        if ({rsp_write, rsp_rdata, rsp_err} !== {e.write, e.rdata, e.err}) begin
                            failures++;
                            $display("FAIL rsp_fields got w=%0b d=%0h e=%0b want w=%0b d=%0h e=%0b",
                                     rsp_write, rsp_rdata, rsp_err, e.write, e.rdata, e.err);
                        end
                    end
                end
                pw_v = bus.m_write_valid; pw_a = bus.m_write_addr; pw_d = bus.m_write_data;
                pr_v = bus.m_read_valid;  pr_a = bus.m_read_addr;
                prs_v = rsp_valid; prs_w = rsp_write; prs_d = rsp_rdata; prs_e = rsp_err;
            end
        end
    end

    // Slave model: ready after a programmable wait, read data only in the
    // cycle after the read handshake (garbage otherwise).
    initial begin : slave
        int wcnt, rcnt;
        bit whold, rhold, rlive;
        wcnt = 0; rcnt = 0; whold = 0; rhold = 0; rlive = 0;
        bus.m_write_ready = 0; bus.m_read_ready = 0; bus.m_read_data = 32'hDEAD_BEEF;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                bus.m_write_ready = 0; bus.m_read_ready = 0; bus.m_read_data = 32'hDEAD_BEEF;
                wcnt = 0; rcnt = 0; whold = 0; rhold = 0; rlive = 0; wr_hs = 0; rd_hs = 0;
            end else begin
                if (wr_hs) begin
                    wr_hs = 0; wcnt = 0;
                    if (keep_ready) whold = 1; else bus.m_write_ready = 0;
                end else if (whold) begin
                    whold = 0; bus.m_write_ready = 0;
                end else if (!bus.m_write_valid) begin
                    wcnt = 0;
                end else if (!bus.m_write_ready) begin
                    if (wcnt >= wr_delay) bus.m_write_ready = 1; else wcnt++;
                end
                if (rlive) begin
                    rlive = 0; bus.m_read_data = 32'hDEAD_BEEF;
                end
                if (rd_hs) begin
                    rd_hs = 0; rcnt = 0; rlive = 1;
                    bus.m_read_data = mem.exists(rd_hs_addr) ? mem[rd_hs_addr] : '0;
                    if (keep_ready) rhold = 1; else bus.m_read_ready = 0;
                end else if (rhold) begin
                    rhold = 0; bus.m_read_ready = 0;
                end else if (!bus.m_read_valid) begin
                    rcnt = 0;
                end else if (!bus.m_read_ready && !rd_block) begin
                    if (rcnt >= rd_delay) bus.m_read_ready = 1; else rcnt++;
                end
            end
        end
    end

    // Offer one command; returns at accept edge + #1 (ok=1) or after budget.
    task automatic send(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input exp_t e, input int budget, output bit ok);
        ok = 0;
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                @(posedge clk);
                exp_q.push_back(e);
                if (w) wr_cmds++;
                ok = 1;
                #1;
                break;
            end
        end
        cmd_valid = 0;
    endtask

    task automatic send_must(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d, input exp_t e);
        bit ok;
        send(w, a, d, e, 100, ok);
        if (!ok) chk("cmd_accept_timeout", 0, 1);
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!busy && !rsp_valid && exp_q.size() == 0) begin done = 1; break; end
        end
        chk(name, done, 1);
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_bus_valid"}, {bus.m_write_valid, bus.m_read_valid}, 0);
        chk({tag, "_bus_addr"}, {bus.m_write_addr, bus.m_read_addr}, 0);
        chk({tag, "_bus_wdata"}, bus.m_write_data, 0);
        chk({tag, "_rsp_ctl"}, {rsp_valid, rsp_write, rsp_err, busy}, 0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
    endtask

    function automatic vec_t mk(bit w, logic [AW-1:0] a, logic [DW-1:0] d, logic [DW-1:0] rd);
        vec_t v;
        v.write = w; v.addr = a; v.data = d;
        v.exp = '{write: w, rdata: rd, err: 1'b0};
        return v;
    endfunction

    initial begin : main
        vec_t tbl[10];
        exp_t wr_ok, e;
        bit   ok, seen;
        int   acc, rd0, cnt;
        logic [AW-1:0] fa[6];
        logic [DW-1:0] fd[6];

        tbl[0] = mk(1, 32'h10,        32'hA5A5_0001, 32'h0);
        tbl[1] = mk(1, 32'h20,        32'h1234_5678, 32'h0);
        tbl[2] = mk(0, 32'h20,        32'h0,         32'h1234_5678);
        tbl[3] = mk(0, 32'h10,        32'h0,         32'hA5A5_0001);
        tbl[4] = mk(1, 32'h30,        32'hFFFF_FFFF, 32'h0);
        tbl[5] = mk(0, 32'h30,        32'h0,         32'hFFFF_FFFF);
        tbl[6] = mk(1, 32'h20,        32'h0,         32'h0);
        tbl[7] = mk(0, 32'h20,        32'h0,         32'h0);
        tbl[8] = mk(1, 32'hFFFF_FFFC, 32'h8000_0001, 32'h0);
        tbl[9] = mk(0, 32'hFFFF_FFFC, 32'h0,         32'h8000_0001);
        wr_ok = '{write: 1'b1, rdata: '0, err: 1'b0};

        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1;
        repeat (3) @(posedge clk);
        #1 chk_reset_outputs("reset");
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;

        // Single write: two-cycle push-to-bus latency, held until slave accepts.
        wr_delay = 3;
        send_must(1, 32'h10, 32'hA5A5_0001, wr_ok);
        @(posedge clk); #1 chk("lat_edge1_valid", bus.m_write_valid, 0);
        @(posedge clk); #1 chk("lat_edge2_valid", bus.m_write_valid, 1);
        chk("wr_addr", bus.m_write_addr, 32'h10);
        chk("wr_data", bus.m_write_data, 32'hA5A5_0001);
        wait_idle("single_write_done");
        chk("single_write_xfers", wr_xfers, 1);

        // Table: queued back-to-back, responses checked in order by the scoreboard.
        wr_delay = 1; rd_delay = 2;
        foreach (tbl[i]) send_must(tbl[i].write, tbl[i].addr, tbl[i].data, tbl[i].exp);
        wait_idle("table_done");

        // FIFO full under response backpressure: 4 queued + 1 in flight.
        rsp_ready = 0; wr_delay = 0; rd_delay = 0; keep_ready = 1;
        fa = '{32'h10, 32'h30, 32'hFFFF_FFFC, 32'h10, 32'h20, 32'h30};
        fd = '{32'hA5A5_0001, 32'hFFFF_FFFF, 32'h8000_0001, 32'hA5A5_0001, 32'h0, 32'hFFFF_FFFF};
        acc = 0; rd0 = rd_xfers;
        for (int i = 0; i < 6; i++) begin
            e = '{write: 1'b0, rdata: fd[i], err: 1'b0};
            send(0, fa[i], 32'h0, e, 20, ok);
            if (ok) acc++;
        end
        chk("fifo_accepted", acc, 5);
        chk("fifo_cmd_ready_low", cmd_ready, 0);
        @(posedge clk); #1 rsp_ready = 1;
        wait_idle("fifo_drain");
        chk("fifo_read_xfers", rd_xfers - rd0, 5);
        keep_ready = 0;

        // Response backpressure: stalled response, next command must not reach the bus.
        rsp_ready = 0;
        send_must(1, 32'h50, 32'h0BAD_F00D, wr_ok);
        send_must(0, 32'h50, 32'h0, '{write: 1'b0, rdata: 32'h0BAD_F00D, err: 1'b0});
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin @(negedge clk); seen = rsp_valid; end
        chk("bp_rsp_seen", seen, 1);
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.m_write_valid || bus.m_read_valid) cnt++;
        end
        chk("bp_no_bus_valid", cnt, 0);
        chk("bp_rsp_held", {rsp_valid, rsp_write}, 2'b11);
        @(posedge clk); #1 rsp_ready = 1;
        wait_idle("bp_drain");

        // Reset while a read is pending on the bus.
        rd_block = 1;
        send_must(0, 32'h10, 32'h0, '{write: 1'b0, rdata: 32'hA5A5_0001, err: 1'b0});
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = bus.m_read_valid; end
        chk("rst_read_pending", seen, 1);
        #2 rst_n = 0;
        #1 chk_reset_outputs("midrst");
        exp_q.delete();
        rd_block = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1;
        cnt = rsp_hi;
        repeat (20) @(negedge clk);
        chk("rst_no_rsp", rsp_hi - cnt, 0);
        @(posedge clk); #1;
        send_must(1, 32'h60, 32'hC0DE_0060, wr_ok);
        send_must(0, 32'h60, 32'h0, '{write: 1'b0, rdata: 32'hC0DE_0060, err: 1'b0});
        wait_idle("post_rst_done");

`ifdef AXI_REQ_TIMEOUT_EN
        // Read of an unwritten address to a slave that never answers.
        rd_block = 1;
        send_must(0, 32'h70, 32'h0, '{write: 1'b0, rdata: 32'h0, err: 1'b1});
        cnt = 0; seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (bus.m_read_valid) cnt++;
            seen = rsp_valid;
        end
        chk("tmo_rsp_seen", seen, 1);
        chk("tmo_valid_cycles", cnt, TMO);
        wait_idle("tmo_done");
        rd_block = 0;
`endif

        chk("never_both_valid", viol_both, 0);
        chk("stability", stab_viol, 0);
        chk("write_xfers_total", wr_xfers, wr_cmds);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
